// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_bus_arbiter
// Description : Shares the single downstream SRAM-bus port of mem2axi among
//               three read requesters (0 icache, 1 dcache, 2 lsu) and two
//               write requesters (0 dcache, 1 lsu). Reads and writes are
//               arbitrated independently, round-robin, one transaction
//               outstanding each. Reads that hit the line of a pending write
//               are held back.
// Ports       : clk, rst_n (async, active-high)
//               rq_*  : read requests in, rq_rdy / rs_* back to requesters
//               wq_*  : write requests in, wq_rdy back to requesters
//               ds_r_*/ds_re_* : downstream read channel
//               ds_w_* : downstream write channel
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bus_arbiter #(
    parameter int LINE_OFF = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   rq_req,
    input  logic [95:0]  rq_addr,
    input  logic [17:0]  rq_type,
    output logic [2:0]   rq_rdy,
    output logic [255:0] rs_data,
    output logic [2:0]   rs_valid,
    input  logic         r0_abort,
    input  logic [1:0]   wq_req,
    input  logic [63:0]  wq_addr,
    input  logic [11:0]  wq_type,
    input  logic [31:0]  wq_strb,
    input  logic [511:0] wq_data,
    output logic [1:0]   wq_rdy,
    output logic         ds_r_req,
    output logic [31:0]  ds_r_addr,
    output logic [5:0]   ds_r_type,
    input  logic         ds_r_rdy,
    input  logic [255:0] ds_re_data,
    input  logic         ds_re_valid,
    output logic         ds_w_req,
    output logic [31:0]  ds_w_addr,
    output logic [5:0]   ds_w_type,
    output logic [15:0]  ds_w_strb,
    output logic [255:0] ds_w_data,
    input  logic         ds_w_rdy
);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_RESP = 2'd2} r_state_t;
    typedef enum logic [0:0] {W_IDLE = 1'b0, W_REQ = 1'b1} w_state_t;

    r_state_t    r_rstate;
    w_state_t    r_wstate;
    logic [1:0]  r_rg;
    logic [1:0]  r_rr_r;
    logic        r_wg;
    logic        r_rr_w;
    logic        r_abort;

    // ------------------------------------------------------------------
    // Read-after-write hazard: a read is held while its line matches the
    // in-flight write, or any requesting write while the write side idles
    // (that write may be granted in the same cycle as the read).
    // ------------------------------------------------------------------
    logic [2:0] w_rd_blk;

    generate
        for (genvar i = 0; i < 3; i++) begin : g_rd_hazard
            logic [31:0] w_ra;
            assign w_ra = rq_addr[32*i +: 32];
            assign w_rd_blk[i] =
                ((r_wstate == W_REQ) && (w_ra[31:LINE_OFF] == ds_w_addr[31:LINE_OFF])) ||
                ((r_wstate == W_IDLE) &&
                 ((wq_req[0] && (w_ra[31:LINE_OFF] == wq_addr[31:LINE_OFF])) ||
                  (wq_req[1] && (w_ra[31:LINE_OFF] == wq_addr[63:32+LINE_OFF]))));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read round-robin: first candidate at or after r_rr_r, wrapping 2->0.
    // Candidate vector is padded to 4 bits so any 2-bit index is in range.
    // ------------------------------------------------------------------
    logic [3:0]  w_r_cand;
    logic [2:0]  w_r_idx;
    logic        w_r_found;
    logic [1:0]  w_r_pick;
    logic [31:0] w_r_sel_addr;
    logic [5:0]  w_r_sel_type;

    assign w_r_cand = {1'b0, rq_req & ~w_rd_blk};

    always_comb begin
        w_r_found = 1'b0;
        w_r_pick  = 2'd0;
        w_r_idx   = 3'd0;
        for (int k = 0; k < 3; k++) begin
            w_r_idx = {1'b0, r_rr_r} + 3'(k);
            if (w_r_idx >= 3'd3) w_r_idx = w_r_idx - 3'd3;
            if (!w_r_found && w_r_cand[w_r_idx[1:0]]) begin
                w_r_found = 1'b1;
                w_r_pick  = w_r_idx[1:0];
            end
        end
    end

    always_comb begin
        case (w_r_pick)
            2'd1:    begin w_r_sel_addr = rq_addr[63:32]; w_r_sel_type = rq_type[11:6];  end
            2'd2:    begin w_r_sel_addr = rq_addr[95:64]; w_r_sel_type = rq_type[17:12]; end
            default: begin w_r_sel_addr = rq_addr[31:0];  w_r_sel_type = rq_type[5:0];   end
        endcase
    end

    // Write round-robin over two ports.
    logic w_w_pick;
    assign w_w_pick = wq_req[r_rr_w] ? r_rr_w : ~r_rr_w;

    // ------------------------------------------------------------------
    // Read-side handshakes. A response may arrive together with the
    // downstream accept, in which case both pulses go out together.
    // ------------------------------------------------------------------
    logic w_r_acc;
    logic w_r_resp;
    logic w_abort_now;

    assign w_r_acc     = (r_rstate == R_REQ) && ds_r_rdy;
    assign w_r_resp    = ((r_rstate == R_RESP) || w_r_acc) && ds_re_valid;
    // An abort arriving in the response cycle itself must also suppress it.
    assign w_abort_now = r_abort || (r0_abort && (r_rg == 2'd0));

    assign rq_rdy   = w_r_acc ? (3'b001 << r_rg) : 3'b000;
    assign rs_valid = (w_r_resp && !((r_rg == 2'd0) && w_abort_now)) ? (3'b001 << r_rg) : 3'b000;
    assign rs_data  = w_r_resp ? ds_re_data : 256'd0;
    assign wq_rdy   = ((r_wstate == W_REQ) && ds_w_rdy) ? (2'b01 << r_wg) : 2'b00;

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_rstate  <= R_IDLE;
            r_rg      <= 2'd0;
            r_rr_r    <= 2'd0;
            r_abort   <= 1'b0;
            ds_r_req  <= 1'b0;
            ds_r_addr <= 32'd0;
            ds_r_type <= 6'd0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_abort <= 1'b0;
                    if (w_r_found) begin
                        r_rg      <= w_r_pick;
                        ds_r_addr <= w_r_sel_addr;
                        ds_r_type <= w_r_sel_type;
                        ds_r_req  <= 1'b1;
                        r_rstate  <= R_REQ;
                    end
                end
                R_REQ: begin
                    if (r0_abort && (r_rg == 2'd0)) r_abort <= 1'b1;
                    if (ds_r_rdy) begin
                        ds_r_req <= 1'b0;
                        r_rr_r   <= (r_rg == 2'd2) ? 2'd0 : r_rg + 2'd1;
                        if (ds_re_valid) begin
                            r_abort  <= 1'b0;
                            r_rstate <= R_IDLE;
                        end else begin
                            r_rstate <= R_RESP;
                        end
                    end
                end
                R_RESP: begin
                    if (r0_abort && (r_rg == 2'd0)) r_abort <= 1'b1;
                    if (ds_re_valid) begin
                        r_abort  <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_wstate  <= W_IDLE;
            r_wg      <= 1'b0;
            r_rr_w    <= 1'b0;
            ds_w_req  <= 1'b0;
            ds_w_addr <= 32'd0;
            ds_w_type <= 6'd0;
            ds_w_strb <= 16'd0;
            ds_w_data <= 256'd0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (|wq_req) begin
                        r_wg      <= w_w_pick;
                        ds_w_addr <= w_w_pick ? wq_addr[63:32]    : wq_addr[31:0];
                        ds_w_type <= w_w_pick ? wq_type[11:6]     : wq_type[5:0];
                        ds_w_strb <= w_w_pick ? wq_strb[31:16]    : wq_strb[15:0];
                        ds_w_data <= w_w_pick ? wq_data[511:256]  : wq_data[255:0];
                        ds_w_req  <= 1'b1;
                        r_wstate  <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (ds_w_rdy) begin
                        ds_w_req <= 1'b0;
                        r_rr_w   <= ~r_wg;
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_bus_arbiter
// Description : Directed self-checking bench for sram_bus_arbiter. Inputs are
//               driven 1 time unit after the rising edge; outputs are sampled
//               1-3 units later, well clear of the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_bus_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   rq_req;
    logic [95:0]  rq_addr;
    logic [17:0]  rq_type;
    logic [2:0]   rq_rdy;
    logic [255:0] rs_data;
    logic [2:0]   rs_valid;
    logic         r0_abort;
    logic [1:0]   wq_req;
    logic [63:0]  wq_addr;
    logic [11:0]  wq_type;
    logic [31:0]  wq_strb;
    logic [511:0] wq_data;
    logic [1:0]   wq_rdy;
    logic         ds_r_req;
    logic [31:0]  ds_r_addr;
    logic [5:0]   ds_r_type;
    logic         ds_r_rdy;
    logic [255:0] ds_re_data;
    logic         ds_re_valid;
    logic         ds_w_req;
    logic [31:0]  ds_w_addr;
    logic [5:0]   ds_w_type;
    logic [15:0]  ds_w_strb;
    logic [255:0] ds_w_data;
    logic         ds_w_rdy;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.LINE_OFF(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .rq_req(rq_req), .rq_addr(rq_addr), .rq_type(rq_type),
        .rq_rdy(rq_rdy), .rs_data(rs_data), .rs_valid(rs_valid),
        .r0_abort(r0_abort),
        .wq_req(wq_req), .wq_addr(wq_addr), .wq_type(wq_type),
        .wq_strb(wq_strb), .wq_data(wq_data), .wq_rdy(wq_rdy),
        .ds_r_req(ds_r_req), .ds_r_addr(ds_r_addr), .ds_r_type(ds_r_type),
        .ds_r_rdy(ds_r_rdy), .ds_re_data(ds_re_data), .ds_re_valid(ds_re_valid),
        .ds_w_req(ds_w_req), .ds_w_addr(ds_w_addr), .ds_w_type(ds_w_type),
        .ds_w_strb(ds_w_strb), .ds_w_data(ds_w_data), .ds_w_rdy(ds_w_rdy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rq_req      = '0; rq_addr = '0; rq_type = '0; r0_abort = 1'b0;
        wq_req      = '0; wq_addr = '0; wq_type = '0; wq_strb  = '0; wq_data = '0;
        ds_r_rdy    = 1'b0; ds_re_data = '0; ds_re_valid = 1'b0; ds_w_rdy = 1'b0;
    endtask

    // Leaves the caller 1 unit after an edge with reset released; the
    // following edge is "cycle 0" of the next scenario.
    task automatic do_reset();
        rst_n = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        rst_n = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    logic [2:0]   grants [$];
    logic [2:0]   exp_g  [4];
    logic [1:0]   exp_w  [6];
    logic [255:0] d_val;

    initial begin
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_w = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

        // ---------------- reset state ----------------
        rst_n = 1'b1;
        idle_inputs();
        #2;
        check("rst_ds_r_req",  ds_r_req,  0);
        check("rst_ds_w_req",  ds_w_req,  0);
        check("rst_rq_rdy",    rq_rdy,    0);
        check("rst_rs_valid",  rs_valid,  0);
        check("rst_wq_rdy",    wq_rdy,    0);
        check("rst_rs_data",   rs_data,   0);
        check("rst_ds_r_addr", ds_r_addr, 0);
        cyc(); cyc();
        rst_n = 1'b0;

        // ---------------- single read, port 1 ----------------
        rq_req = 3'b010; rq_addr[63:32] = 32'h8000_0040; rq_type[11:6] = 6'h05;
        #1; check("t1_c0_ds_r_req", ds_r_req, 0);
        cyc(); #1;
        check("t1_c1_ds_r_req",  ds_r_req,  1);
        check("t1_c1_ds_r_addr", ds_r_addr, 32'h8000_0040);
        check("t1_c1_ds_r_type", ds_r_type, 6'h05);
        check("t1_c1_rq_rdy",    rq_rdy,    0);
        cyc(); cyc();
        ds_r_rdy = 1'b1; #1;
        check("t1_c3_rq_rdy",   rq_rdy,   3'b010);
        check("t1_c3_rs_valid", rs_valid, 3'b000);
        cyc(); ds_r_rdy = 1'b0; rq_req = 3'b000; #1;
        check("t1_c4_ds_r_req", ds_r_req, 0);
        check("t1_c4_rq_rdy",   rq_rdy,   0);
        cyc(); cyc();
        d_val = {8{32'hA5A5_0F0F}};
        ds_re_valid = 1'b1; ds_re_data = d_val; #1;
        check("t1_c6_rs_valid", rs_valid, 3'b010);
        check("t1_c6_rs_data",  rs_data,  d_val);
        cyc(); ds_re_valid = 1'b0; #1;
        check("t1_c7_rs_valid", rs_valid, 0);
        check("t1_c7_rs_data",  rs_data,  0);

        // ---------------- read round-robin ----------------
        do_reset();
        rq_addr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        rq_req = 3'b111; ds_r_rdy = 1'b1; ds_re_valid = 1'b1; ds_re_data = 256'h1234;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (rq_rdy != 3'b000) begin
                check("rr_resp_with_rdy", rs_valid, rq_rdy);
                grants.push_back(rq_rdy);
            end
            cyc();
        end
        check("rr_grant_count_ge4", grants.size() >= 4, 1);
        for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), grants[i], exp_g[i]);

        // ---------------- read-after-write hazard ----------------
        do_reset();
        wq_req = 2'b01; wq_addr[31:0] = 32'h8000_0020; wq_type[5:0] = 6'h11;
        rq_req = 3'b110; rq_addr[63:32] = 32'h8000_0100; rq_addr[95:64] = 32'h8000_0038;
        cyc();
        ds_r_rdy = 1'b1; ds_re_valid = 1'b1; #1;
        check("hz_c1_ds_w_req",   ds_w_req,  1);
        check("hz_c1_ds_w_addr",  ds_w_addr, 32'h8000_0020);
        check("hz_c1_ds_r_req",   ds_r_req,  1);
        check("hz_c1_ds_r_addr",  ds_r_addr, 32'h8000_0100);
        check("hz_c1_rq_rdy",     rq_rdy,    3'b010);
        check("hz_c1_rs_valid",   rs_valid,  3'b010);
        cyc();
        ds_r_rdy = 1'b0; ds_re_valid = 1'b0; rq_req = 3'b100;
        for (int c = 2; c <= 5; c++) begin
            if (c == 5) ds_w_rdy = 1'b1;
            #1;
            check($sformatf("hz_c%0d_blocked", c), ds_r_req, 0);
            if (c == 5) check("hz_c5_wq_rdy", wq_rdy, 2'b01);
            cyc();
        end
        ds_w_rdy = 1'b0; wq_req = 2'b00; #1;
        check("hz_c6_ds_r_req", ds_r_req, 0);
        check("hz_c6_ds_w_req", ds_w_req, 0);
        cyc();
        ds_r_rdy = 1'b1; ds_re_valid = 1'b1; #1;
        check("hz_c7_ds_r_req",  ds_r_req,  1);
        check("hz_c7_ds_r_addr", ds_r_addr, 32'h8000_0038);
        check("hz_c7_rq_rdy",    rq_rdy,    3'b100);

        // ---------------- icache abort ----------------
        do_reset();
        rq_req = 3'b011; rq_addr[31:0] = 32'h0000_1000; rq_addr[63:32] = 32'h0000_2000;
        cyc();
        ds_r_rdy = 1'b1; #1;
        check("ab_c1_ds_r_addr", ds_r_addr, 32'h0000_1000);
        check("ab_c1_rq_rdy",    rq_rdy,    3'b001);
        cyc();
        ds_r_rdy = 1'b0; rq_req = 3'b010; r0_abort = 1'b1; #1;
        check("ab_c2_rs_valid", rs_valid, 0);
        cyc();
        r0_abort = 1'b0; ds_re_valid = 1'b1; ds_re_data = 256'hBEEF; #1;
        check("ab_c3_suppressed", rs_valid, 0);
        cyc();
        ds_re_valid = 1'b0; rq_req = 3'b011; #1;
        check("ab_c4_ds_r_req", ds_r_req, 0);
        cyc();
        ds_r_rdy = 1'b1; ds_re_valid = 1'b1; r0_abort = 1'b1; #1;
        check("ab_c5_ds_r_addr", ds_r_addr, 32'h0000_2000);
        check("ab_c5_rq_rdy",    rq_rdy,    3'b010);
        check("ab_c5_rs_valid",  rs_valid,  3'b010);
        cyc();
        idle_inputs();

        // ---------------- write alternation ----------------
        do_reset();
        wq_req = 2'b11; ds_w_rdy = 1'b1;
        wq_addr = {32'hB000_0000, 32'hA000_0000};
        wq_type = {6'h02, 6'h01};
        wq_strb = {16'h00F0, 16'hFFFF};
        wq_data[255:0]   = {8{32'h1111_2222}};
        wq_data[511:256] = {192'd0, 64'hDEAD_BEEF_CAFE_F00D};
        #1; check("wr_c0_ds_w_req", ds_w_req, 0);
        for (int c = 1; c <= 5; c++) begin
            cyc(); #1;
            check($sformatf("wr_c%0d_wq_rdy", c), wq_rdy, exp_w[c]);
            if (c == 1) begin
                check("wr_c1_addr", ds_w_addr, 32'hA000_0000);
                check("wr_c1_strb", ds_w_strb, 16'hFFFF);
                check("wr_c1_data", ds_w_data, {8{32'h1111_2222}});
            end
            if (c == 3) begin
                check("wr_c3_addr",     ds_w_addr, 32'hB000_0000);
                check("wr_c3_type",     ds_w_type, 6'h02);
                check("wr_c3_strb",     ds_w_strb, 16'h00F0);
                check("wr_c3_data",     ds_w_data, {192'd0, 64'hDEAD_BEEF_CAFE_F00D});
                check("wr_c3_data_hi0", ds_w_data[255:64], 0);
            end
        end

        // ---------------- reset mid-flight ----------------
        do_reset();
        rq_req = 3'b001; rq_addr[31:0] = 32'h0000_4000;
        wq_req = 2'b01;  wq_addr[31:0] = 32'h9000_0000;
        cyc();
        ds_r_rdy = 1'b1; #1;
        check("rm_c1_rq_rdy", rq_rdy, 3'b001);
        cyc();
        ds_r_rdy = 1'b0; rq_req = 3'b000;
        ds_re_valid = 1'b1; ds_re_data = 256'h77; #1;
        check("rm_pre_rs_valid", rs_valid, 3'b001);
        check("rm_pre_ds_w_req", ds_w_req, 1);
        rst_n = 1'b1; #1;
        check("rm_rs_valid",  rs_valid,  0);
        check("rm_rs_data",   rs_data,   0);
        check("rm_ds_r_req",  ds_r_req,  0);
        check("rm_ds_r_addr", ds_r_addr, 0);
        check("rm_ds_w_req",  ds_w_req,  0);
        check("rm_ds_w_addr", ds_w_addr, 0);
        cyc();
        rst_n = 1'b0; wq_req = 2'b00; #1;
        check("rm_stray_rs_valid0", rs_valid, 0);
        cyc(); #1;
        check("rm_stray_rs_valid1", rs_valid, 0);
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
